hazard_fwd_ctrl: RTL and testbench
==================================

// Module: hazard_fwd_ctrl
// PURPOSE
//  Parametrised hazard/forwarding controller for the RV32I 5-stage pipeline (IF/ID/EX/MEM/WB).
//  Produces per-source forwarding selects, load-use stalls with bubble insertion, and
//  branch/jump redirect flushes via a small RUN/STALL/FLUSH state machine.
//  Sits beside the main decode controller and drives the ALU operand muxes, pipeline-register
//  enables/flushes and the PC source mux.
// PARAMETERS
//  REG_AW      5  register-address width
//  NUM_SRC     2  source operands checked per ID instruction (2..3)
//  LOAD_STALL  1  total stall cycles per load-use hit (1..4)
//  FLUSH_CYC   2  total cycles flush_id is asserted per redirect (1..4)
//  CNT_W       16 perf-counter width (HAZARD_PERF_CNT_EN only)
// PORTS
//  clk          in   1                  clock, rising edge
//  rst          in   1                  synchronous, active-high reset
//  id_valid     in   1                  ID holds a valid instruction
//  id_rs_addr   in   NUM_SRC*REG_AW     source i at [i*REG_AW +: REG_AW]
//  id_rs_used   in   NUM_SRC            bit i: source i is actually read
//  ex_rd_addr   in   REG_AW             EX destination; ex_wb_en: EX writes back (1)
//  ex_is_load   in   1                  EX instruction is a load
//  mem_rd_addr  in   REG_AW             MEM destination; mem_wb_en (1)
//  wb_rd_addr   in   REG_AW             WB destination; wb_wb_en (1)
//  ex_redirect  in   1                  EX resolved taken branch or JAL/JALR
//  fwd_sel      out  2*NUM_SRC          per source: 00 RF, 01 EX, 10 MEM, 11 WB (registered)
//  stall_if     out  1                  hold PC
//  stall_id     out  1                  hold IF/ID register
//  flush_id     out  1                  zero IF/ID register
//  flush_ex     out  1                  insert bubble into ID/EX register
//  pc_sel       out  2                  00 PC+4, 01 redirect target (ALU out)
//  instr_sel    out  2                  00 fetched instr, 10 NOP (registered)
//  stall_cnt    out  CNT_W              load-use stall cycles (HAZARD_PERF_CNT_EN only)
//  flush_cnt    out  CNT_W              redirect events (HAZARD_PERF_CNT_EN only)
// BEHAVIOUR
//  Reset: state=RUN, counters=0, fwd_sel=0, instr_sel=00. All combinational outputs read 0 while rst=1.
//  Match(i, stage) = id_rs_used[i] & stage_wb_en & (rs_i == stage_rd) & (rs_i != 0); x0 never forwards.
//  fwd_sel[i] registered at posedge from ID-stage inputs; priority EX > MEM > WB > RF.
//   Value applies to the instruction entering EX next cycle. While stall_id=1, fwd_sel is recomputed
//   each cycle from the held ID instruction.
//  load_hit = id_valid & ex_is_load & any_i Match(i,EX).
//  FSM (state registered, outputs Mealy on state + current inputs):
//   RUN:   redirect -> pc_sel=01, flush_id=1, flush_ex=1; next FLUSH if FLUSH_CYC>1.
//          else load_hit -> stall_if=stall_id=flush_ex=1; next STALL if LOAD_STALL>1.
//   STALL: stall_if=stall_id=flush_ex=1; cnt-- each cycle; -> RUN after LOAD_STALL-1 cycles.
//          redirect in STALL aborts the stall and takes the RUN redirect path (same cycle).
//   FLUSH: flush_id=1, pc_sel=00, stalls and load_hit ignored; -> RUN after FLUSH_CYC-1 cycles.
//          redirect in FLUSH re-arms: pc_sel=01 and cnt reloaded to FLUSH_CYC-1.
//  Priority: rst > ex_redirect > load_hit.
//  Simultaneous redirect and load_hit: no stall; the ID instruction is flushed.
//  instr_sel <= 10 the cycle after any cycle with pc_sel=01, else 00.
//  Reset mid-STALL/FLUSH: state returns to RUN in the same cycle; no residual stall or flush.
//  Cycle counter width: $clog2(max(LOAD_STALL,FLUSH_CYC))+1.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined:
//   stall_cnt increments each cycle stall_if=1.
//   flush_cnt increments on each cycle with pc_sel=01.
//   Both saturate at all-ones and clear on rst.
//  HAZARD_PERF_CNT_EN undefined: stall_cnt/flush_cnt ports and logic are absent.
// TESTING
//  ID rs1=5 used; EX rd=5 wb_en=1, not a load -> next cycle fwd_sel[1:0]=01, no stall.
//  rs1=5 with EX rd=5 and MEM rd=5, both wb_en -> fwd_sel[1:0]=01 (EX wins).
//  rs2=0 with EX rd=0 wb_en=1 -> fwd_sel[3:2]=00.
//  EX lw rd=7, ID add rs2=7, LOAD_STALL=1 -> stall_if/stall_id/flush_ex=1 for exactly 1 cycle.
//   The following cycle fwd_sel[3:2]=10.
//  ex_redirect=1, FLUSH_CYC=2 -> pc_sel=01 for 1 cycle, flush_id=1 for 2 cycles, instr_sel=10 next cycle.
//  LOAD_STALL=3: rst=1 during the 2nd stall cycle -> all outputs 0 next cycle, state RUN.
//  Simultaneous redirect and load_hit -> no stall; pc_sel=01, flush_id=flush_ex=1.
//  HAZARD_PERF_CNT_EN, CNT_W=4: 20 stall cycles -> stall_cnt=15 (saturated).

Source files
------------

// File: rtl/hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_fwd_ctrl
// Purpose  : Hazard and forwarding controller for a 5-stage RV32I pipeline.
//            It produces registered per-source forwarding selects (EX > MEM >
//            WB > RF), load-use stalls with bubble insertion, and branch/jump
//            redirect flushes, sequenced by a RUN/STALL/FLUSH machine.
// Ports    : clk, rst                 clock / synchronous active-high reset
//            id_*_i                   ID instruction sources and valid
//            ex_/mem_/wb_*_i          destination address + write-back enables
//            ex_is_load_i             EX instruction is a load
//            ex_redirect_i            EX resolved a taken branch / JAL / JALR
//            fwd_sel_o                2 bits per source: 00 RF 01 EX 10 MEM 11 WB
//            stall_if_o, stall_id_o   hold PC / hold IF/ID
//            flush_id_o, flush_ex_o   zero IF/ID / bubble into ID/EX
//            pc_sel_o                 00 PC+4, 01 redirect target
//            instr_sel_o              00 fetched instruction, 10 NOP
//            stall_cnt_o, flush_cnt_o saturating perf counters
// Config   : `define HAZARD_PERF_CNT_EN to add the perf counters and ports.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_fwd_ctrl #(
    parameter int REG_AW     = 5,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_STALL = 1,
    parameter int FLUSH_CYC  = 2,
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid_i,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs_addr_i,
    input  logic [NUM_SRC-1:0]        id_rs_used_i,
    input  logic [REG_AW-1:0]         ex_rd_addr_i,
    input  logic                      ex_wb_en_i,
    input  logic                      ex_is_load_i,
    input  logic [REG_AW-1:0]         mem_rd_addr_i,
    input  logic                      mem_wb_en_i,
    input  logic [REG_AW-1:0]         wb_rd_addr_i,
    input  logic                      wb_wb_en_i,
    input  logic                      ex_redirect_i,
    output logic [2*NUM_SRC-1:0]      fwd_sel_o,
    output logic                      stall_if_o,
    output logic                      stall_id_o,
    output logic                      flush_id_o,
    output logic                      flush_ex_o,
    output logic [1:0]                pc_sel_o,
    output logic [1:0]                instr_sel_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]          stall_cnt_o,
    output logic [CNT_W-1:0]          flush_cnt_o
`endif
);

    localparam int MAXC = (LOAD_STALL > FLUSH_CYC) ? LOAD_STALL : FLUSH_CYC;
    localparam int CW   = $clog2(MAXC) + 1;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_EX      = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;
    localparam logic [1:0] FWD_WB      = 2'b11;
    localparam logic [1:0] PC_SEQ      = 2'b00;
    localparam logic [1:0] PC_REDIR    = 2'b01;
    localparam logic [1:0] INSTR_FETCH = 2'b00;
    localparam logic [1:0] INSTR_NOP   = 2'b10;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*NUM_SRC-1:0] fwd_sel_q, fwd_sel_d;
    logic [1:0]          instr_sel_q;
    logic [NUM_SRC-1:0]  ex_match;
    logic                load_hit;

    // Per-source match against each downstream destination; x0 never forwards.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [REG_AW-1:0] rs;
        logic              live;
        logic              m_ex, m_mem, m_wb;

        assign rs    = id_rs_addr_i[i*REG_AW +: REG_AW];
        assign live  = id_rs_used_i[i] & (|rs);
        assign m_ex  = live & ex_wb_en_i  & (rs == ex_rd_addr_i);
        assign m_mem = live & mem_wb_en_i & (rs == mem_rd_addr_i);
        assign m_wb  = live & wb_wb_en_i  & (rs == wb_rd_addr_i);

        assign ex_match[i]        = m_ex;
        assign fwd_sel_d[2*i +: 2] = m_ex  ? FWD_EX  :
                                     m_mem ? FWD_MEM :
                                     m_wb  ? FWD_WB  : FWD_RF;
    end

    assign load_hit = id_valid_i & ex_is_load_i & (|ex_match);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            cnt_q       <= '0;
            fwd_sel_q   <= '0;
            instr_sel_q <= INSTR_FETCH;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            // Recomputed every cycle, so a held ID instruction picks up the
            // load result from MEM once the bubble has gone through.
            fwd_sel_q   <= fwd_sel_d;
            instr_sel_q <= (pc_sel_o == PC_REDIR) ? INSTR_NOP : INSTR_FETCH;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_if_o = 1'b0;
        stall_id_o = 1'b0;
        flush_id_o = 1'b0;
        flush_ex_o = 1'b0;
        pc_sel_o   = PC_SEQ;

        case (state_q)
            S_RUN, S_STALL: begin
                if (ex_redirect_i) begin
                    // Redirect wins over a load-use hit (and aborts a running
                    // stall): the ID instruction is on the wrong path anyway.
                    pc_sel_o   = PC_REDIR;
                    flush_id_o = 1'b1;
                    flush_ex_o = 1'b1;
                    if (FLUSH_CYC > 1) begin
                        state_d = S_FLUSH;
                        cnt_d   = CW'(FLUSH_CYC - 1);
                    end else begin
                        state_d = S_RUN;
                    end
                end else if (state_q == S_STALL) begin
                    stall_if_o = 1'b1;
                    stall_id_o = 1'b1;
                    flush_ex_o = 1'b1;
                    cnt_d      = cnt_q - CW'(1);
                    if (cnt_q <= CW'(1)) begin
                        state_d = S_RUN;
                    end
                end else if (load_hit) begin
                    stall_if_o = 1'b1;
                    stall_id_o = 1'b1;
                    flush_ex_o = 1'b1;
                    if (LOAD_STALL > 1) begin
                        state_d = S_STALL;
                        cnt_d   = CW'(LOAD_STALL - 1);
                    end
                end
            end
            S_FLUSH: begin
                flush_id_o = 1'b1;
                if (ex_redirect_i) begin
                    pc_sel_o = PC_REDIR;
                    cnt_d    = CW'(FLUSH_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q <= CW'(1)) begin
                        state_d = S_RUN;
                    end
                end
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
        endcase

        if (rst) begin
            stall_if_o = 1'b0;
            stall_id_o = 1'b0;
            flush_id_o = 1'b0;
            flush_ex_o = 1'b0;
            pc_sel_o   = PC_SEQ;
        end
    end

    assign fwd_sel_o   = fwd_sel_q;
    assign instr_sel_o = instr_sel_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_if_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if ((pc_sel_o == PC_REDIR) && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_fwd_ctrl
// Purpose  : Directed self-checking bench. Two instances share all inputs:
//            dut_a (LOAD_STALL=1, FLUSH_CYC=2) and dut_b (LOAD_STALL=3,
//            FLUSH_CYC=2). Inputs change 1 ns after the rising edge;
//            combinational outputs are sampled 2 ns later, registered ones
//            1 ns after the edge that loads them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [9:0] id_rs_addr;
    logic [1:0] id_rs_used;
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic       ex_wb_en, ex_is_load, mem_wb_en, wb_wb_en, ex_redirect;

    logic [3:0] fwd_a, fwd_b;
    logic       stall_if_a, stall_id_a, flush_id_a, flush_ex_a;
    logic       stall_if_b, stall_id_b, flush_id_b, flush_ex_b;
    logic [1:0] pc_sel_a, instr_sel_a, pc_sel_b, instr_sel_b;
`ifdef HAZARD_PERF_CNT_EN
    logic [3:0] stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(.REG_AW(5), .NUM_SRC(2), .LOAD_STALL(1), .FLUSH_CYC(2), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_rs_addr_i(id_rs_addr),
        .id_rs_used_i(id_rs_used), .ex_rd_addr_i(ex_rd), .ex_wb_en_i(ex_wb_en),
        .ex_is_load_i(ex_is_load), .mem_rd_addr_i(mem_rd), .mem_wb_en_i(mem_wb_en),
        .wb_rd_addr_i(wb_rd), .wb_wb_en_i(wb_wb_en), .ex_redirect_i(ex_redirect),
        .fwd_sel_o(fwd_a), .stall_if_o(stall_if_a), .stall_id_o(stall_id_a),
        .flush_id_o(flush_id_a), .flush_ex_o(flush_ex_a), .pc_sel_o(pc_sel_a),
        .instr_sel_o(instr_sel_a)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt_o(stall_cnt_a), .flush_cnt_o(flush_cnt_a)
`endif
    );

    hazard_fwd_ctrl #(.REG_AW(5), .NUM_SRC(2), .LOAD_STALL(3), .FLUSH_CYC(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_rs_addr_i(id_rs_addr),
        .id_rs_used_i(id_rs_used), .ex_rd_addr_i(ex_rd), .ex_wb_en_i(ex_wb_en),
        .ex_is_load_i(ex_is_load), .mem_rd_addr_i(mem_rd), .mem_wb_en_i(mem_wb_en),
        .wb_rd_addr_i(wb_rd), .wb_wb_en_i(wb_wb_en), .ex_redirect_i(ex_redirect),
        .fwd_sel_o(fwd_b), .stall_if_o(stall_if_b), .stall_id_o(stall_id_b),
        .flush_id_o(flush_id_b), .flush_ex_o(flush_ex_b), .pc_sel_o(pc_sel_b),
        .instr_sel_o(instr_sel_b)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt_o(stall_cnt_b), .flush_cnt_o(flush_cnt_b)
`endif
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid    = 1'b0;
        id_rs_addr  = '0;
        id_rs_used  = '0;
        ex_rd       = '0;
        ex_wb_en    = 1'b0;
        ex_is_load  = 1'b0;
        mem_rd      = '0;
        mem_wb_en   = 1'b0;
        wb_rd       = '0;
        wb_wb_en    = 1'b0;
        ex_redirect = 1'b0;
    endtask

    // EX holds a load writing rd=7, ID reads rs2=7.
    task automatic drive_load_use();
        idle();
        id_valid   = 1'b1;
        id_rs_addr = {5'd7, 5'd0};
        id_rs_used = 2'b10;
        ex_rd      = 5'd7;
        ex_wb_en   = 1'b1;
        ex_is_load = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        cyc();
        cyc();
        ex_redirect = 1'b1;
        drive_load_use();
        ex_redirect = 1'b1;
        #2;
        checks++; if (pc_sel_a !== 2'b00) begin errors++; $display("FAIL reset_pc_sel got %b exp 00", pc_sel_a); end
        checks++; if ({stall_if_a, stall_id_a, flush_id_a, flush_ex_a} !== 4'b0000) begin errors++; $display("FAIL reset_comb_a got %b exp 0000", {stall_if_a, stall_id_a, flush_id_a, flush_ex_a}); end
        checks++; if ({stall_if_b, flush_id_b, flush_ex_b, pc_sel_b} !== 5'b00000) begin errors++; $display("FAIL reset_comb_b got %b exp 00000", {stall_if_b, flush_id_b, flush_ex_b, pc_sel_b}); end
        cyc();
        checks++; if (fwd_a !== 4'b0000) begin errors++; $display("FAIL reset_fwd got %b exp 0000", fwd_a); end
        checks++; if (instr_sel_a !== 2'b00) begin errors++; $display("FAIL reset_instr_sel got %b exp 00", instr_sel_a); end
        rst = 1'b0;
        idle();
        cyc();
    endtask

    task automatic test_fwd_ex();
        idle();
        id_valid   = 1'b1;
        id_rs_addr = {5'd0, 5'd5};
        id_rs_used = 2'b01;
        ex_rd      = 5'd5;
        ex_wb_en   = 1'b1;
        #2;
        checks++; if ({stall_if_a, stall_id_a, flush_ex_a} !== 3'b000) begin errors++; $display("FAIL fwd_ex_nostall got %b exp 000", {stall_if_a, stall_id_a, flush_ex_a}); end
        cyc();
        checks++; if (fwd_a !== 4'b0001) begin errors++; $display("FAIL fwd_ex got %b exp 0001", fwd_a); end
    endtask

    task automatic test_fwd_priority();
        idle();
        id_valid   = 1'b1;
        id_rs_addr = {5'd9, 5'd5};
        id_rs_used = 2'b11;
        ex_rd      = 5'd5;  ex_wb_en  = 1'b1;
        mem_rd     = 5'd5;  mem_wb_en = 1'b1;
        wb_rd      = 5'd9;  wb_wb_en  = 1'b1;
        cyc();
        checks++; if (fwd_a !== 4'b1101) begin errors++; $display("FAIL fwd_ex_over_mem got %b exp 1101", fwd_a); end
        ex_wb_en = 1'b0;
        cyc();
        checks++; if (fwd_a !== 4'b1110) begin errors++; $display("FAIL fwd_mem got %b exp 1110", fwd_a); end
        mem_wb_en  = 1'b0;
        wb_rd      = 5'd5;
        cyc();
        checks++; if (fwd_a !== 4'b0011) begin errors++; $display("FAIL fwd_wb got %b exp 0011", fwd_a); end
        id_rs_used = 2'b00;
        cyc();
        checks++; if (fwd_a !== 4'b0000) begin errors++; $display("FAIL fwd_unused got %b exp 0000", fwd_a); end
    endtask

    task automatic test_x0();
        idle();
        id_valid   = 1'b1;
        id_rs_addr = {5'd0, 5'd0};
        id_rs_used = 2'b10;
        ex_rd      = 5'd0;  ex_wb_en  = 1'b1;
        mem_rd     = 5'd0;  mem_wb_en = 1'b1;
        ex_is_load = 1'b1;
        #2;
        checks++; if (stall_if_a !== 1'b0) begin errors++; $display("FAIL x0_nostall got %b exp 0", stall_if_a); end
        cyc();
        checks++; if (fwd_a !== 4'b0000) begin errors++; $display("FAIL x0_fwd got %b exp 0000", fwd_a); end
        idle();
    endtask

    task automatic test_load_use();
        drive_load_use();
        #2;
        checks++; if ({stall_if_a, stall_id_a, flush_ex_a, flush_id_a, pc_sel_a} !== 6'b111000) begin errors++; $display("FAIL lu_stall_a got %b exp 111000", {stall_if_a, stall_id_a, flush_ex_a, flush_id_a, pc_sel_a}); end
        checks++; if ({stall_if_b, stall_id_b, flush_ex_b} !== 3'b111) begin errors++; $display("FAIL lu_stall_b1 got %b exp 111", {stall_if_b, stall_id_b, flush_ex_b}); end
        cyc();
        checks++; if (fwd_a !== 4'b0100) begin errors++; $display("FAIL lu_fwd_ex got %b exp 0100", fwd_a); end
        // Bubble in EX, load moves to MEM, ID instruction held.
        ex_rd = 5'd0; ex_wb_en = 1'b0; ex_is_load = 1'b0;
        mem_rd = 5'd7; mem_wb_en = 1'b1;
        #2;
        checks++; if ({stall_if_a, stall_id_a, flush_ex_a} !== 3'b000) begin errors++; $display("FAIL lu_one_cycle got %b exp 000", {stall_if_a, stall_id_a, flush_ex_a}); end
        checks++; if (stall_if_b !== 1'b1) begin errors++; $display("FAIL lu_b_cycle2 got %b exp 1", stall_if_b); end
        cyc();
        checks++; if (fwd_a !== 4'b1000) begin errors++; $display("FAIL lu_fwd_mem got %b exp 1000", fwd_a); end
        idle();
        #2;
        checks++; if ({stall_if_b, stall_id_b, flush_ex_b} !== 3'b111) begin errors++; $display("FAIL lu_b_cycle3 got %b exp 111", {stall_if_b, stall_id_b, flush_ex_b}); end
        cyc();
        checks++; if (stall_if_b !== 1'b0) begin errors++; $display("FAIL lu_b_done got %b exp 0", stall_if_b); end
    endtask

    task automatic test_redirect();
        idle();
        ex_redirect = 1'b1;
        #2;
        checks++; if ({pc_sel_a, flush_id_a, flush_ex_a} !== 4'b0111) begin errors++; $display("FAIL redir_c1 got %b exp 0111", {pc_sel_a, flush_id_a, flush_ex_a}); end
        cyc();
        ex_redirect = 1'b0;
        #2;
        checks++; if ({pc_sel_a, flush_id_a, flush_ex_a} !== 4'b0010) begin errors++; $display("FAIL redir_c2 got %b exp 0010", {pc_sel_a, flush_id_a, flush_ex_a}); end
        checks++; if (instr_sel_a !== 2'b10) begin errors++; $display("FAIL redir_nop got %b exp 10", instr_sel_a); end
        cyc();
        checks++; if ({flush_id_a, instr_sel_a} !== 3'b000) begin errors++; $display("FAIL redir_c3 got %b exp 000", {flush_id_a, instr_sel_a}); end
    endtask

    task automatic test_flush_rearm();
        idle();
        ex_redirect = 1'b1;
        cyc();
        #2;
        checks++; if ({pc_sel_a, flush_id_a, flush_ex_a} !== 4'b0110) begin errors++; $display("FAIL rearm_c2 got %b exp 0110", {pc_sel_a, flush_id_a, flush_ex_a}); end
        cyc();
        ex_redirect = 1'b0;
        #2;
        checks++; if ({flush_id_a, pc_sel_a, instr_sel_a} !== 5'b10010) begin errors++; $display("FAIL rearm_c3 got %b exp 10010", {flush_id_a, pc_sel_a, instr_sel_a}); end
        cyc();
        checks++; if (flush_id_a !== 1'b0) begin errors++; $display("FAIL rearm_end got %b exp 0", flush_id_a); end
    endtask

    task automatic test_reset_mid_stall();
        drive_load_use();
        cyc();
        idle();
        rst = 1'b1;
        #2;
        checks++; if ({stall_if_b, stall_id_b, flush_ex_b} !== 3'b000) begin errors++; $display("FAIL rst_stall_now got %b exp 000", {stall_if_b, stall_id_b, flush_ex_b}); end
        cyc();
        rst = 1'b0;
        #2;
        checks++; if ({stall_if_b, stall_id_b, flush_id_b, flush_ex_b, pc_sel_b, instr_sel_b, fwd_b} !== 12'h000) begin errors++; $display("FAIL rst_stall_next got %h exp 000", {stall_if_b, stall_id_b, flush_id_b, flush_ex_b, pc_sel_b, instr_sel_b, fwd_b}); end
        cyc();
        checks++; if (stall_if_b !== 1'b0) begin errors++; $display("FAIL rst_stall_run got %b exp 0", stall_if_b); end
    endtask

    task automatic test_redirect_and_load();
        drive_load_use();
        ex_redirect = 1'b1;
        #2;
        checks++; if ({stall_if_a, stall_id_a, pc_sel_a, flush_id_a, flush_ex_a} !== 6'b000111) begin errors++; $display("FAIL rl_a got %b exp 000111", {stall_if_a, stall_id_a, pc_sel_a, flush_id_a, flush_ex_a}); end
        checks++; if ({stall_if_b, stall_id_b, pc_sel_b, flush_id_b, flush_ex_b} !== 6'b000111) begin errors++; $display("FAIL rl_b got %b exp 000111", {stall_if_b, stall_id_b, pc_sel_b, flush_id_b, flush_ex_b}); end
        cyc();
        idle();
        #2;
        checks++; if ({stall_if_b, flush_id_b} !== 2'b01) begin errors++; $display("FAIL rl_b_c2 got %b exp 01", {stall_if_b, flush_id_b}); end
        cyc();
    endtask

    task automatic test_redirect_in_stall();
        drive_load_use();
        cyc();
        idle();
        ex_redirect = 1'b1;
        #2;
        checks++; if ({stall_if_b, stall_id_b, pc_sel_b, flush_id_b, flush_ex_b} !== 6'b000111) begin errors++; $display("FAIL ris_abort got %b exp 000111", {stall_if_b, stall_id_b, pc_sel_b, flush_id_b, flush_ex_b}); end
        cyc();
        ex_redirect = 1'b0;
        #2;
        checks++; if ({stall_if_b, flush_id_b, pc_sel_b} !== 4'b0100) begin errors++; $display("FAIL ris_flush got %b exp 0100", {stall_if_b, flush_id_b, pc_sel_b}); end
        cyc();
        checks++; if ({stall_if_b, flush_id_b} !== 2'b00) begin errors++; $display("FAIL ris_run got %b exp 00", {stall_if_b, flush_id_b}); end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_cnt();
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++; if ({stall_cnt_a, flush_cnt_a} !== 8'h00) begin errors++; $display("FAIL perf_clear got %h exp 00", {stall_cnt_a, flush_cnt_a}); end
        drive_load_use();
        for (int k = 0; k < 10; k++) cyc();
        checks++; if (stall_cnt_a !== 4'd10) begin errors++; $display("FAIL perf_stall10 got %0d exp 10", stall_cnt_a); end
        for (int k = 0; k < 10; k++) cyc();
        checks++; if (stall_cnt_a !== 4'd15) begin errors++; $display("FAIL perf_stall_sat got %0d exp 15", stall_cnt_a); end
        checks++; if (stall_cnt_b !== 4'd15) begin errors++; $display("FAIL perf_stall_sat_b got %0d exp 15", stall_cnt_b); end
        idle();
        ex_redirect = 1'b1;
        cyc();
        ex_redirect = 1'b0;
        cyc();
        cyc();
        checks++; if (flush_cnt_a !== 4'd1) begin errors++; $display("FAIL perf_flush got %0d exp 1", flush_cnt_a); end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fwd_ex();
        test_fwd_priority();
        test_x0();
        test_load_use();
        test_redirect();
        test_flush_rearm();
        test_reset_mid_stall();
        test_redirect_and_load();
        test_redirect_in_stall();
`ifdef HAZARD_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
